idli_sqi_mem_ctrl: RTL
======================

Name: idli_sqi_mem_ctrl

Overview:
- Quad-SPI (SQI) SRAM sequencer between the idli core's memory request port and the top-level uio pins.
- Converts one 16-bit word read or write request into a complete SQI transaction: command byte, 24-bit byte address, optional dummy nibbles, then 4 data nibbles.
- Returns the read data or a write acknowledge to the core.
- Instantiated inside tt_um_theultimat_idli_top; the pin-side ports map onto uio_out/uio_oe/uio_in.

Parameters:
- CMD_READ, 8'h03, SQI read command byte.
- CMD_WRITE, 8'h02, SQI write command byte.
- DUMMY_NIBBLES, 2, turnaround nibbles between address and read data; range 0-7.

Ports:
- clk  in  1  single design clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  16  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
- rsp_rdata  out  16  read data; held until the next read completes.
- sck  out  1  SQI serial clock.
- cs_n  out  1  SQI chip select, active low.
- sio_out  out  4  SQI data out.
- sio_oe  out  1  1=drive sio_out onto the pins.
- sio_in  in  4  SQI data in.

Behaviour:
- Reset (rst high at a clk edge) takes effect on the next edge and aborts any transaction:
  - state=IDLE, cs_n=1, sck=0, sio_oe=0, sio_out=0, rsp_valid=0, rsp_rdata=0.
  - req_ready=0 while rst is high; req_ready=1 on the first cycle after rst falls.
- Accept: req_valid && req_ready at edge T. Latch req_we, req_addr and req_wdata; req_ready drops to 0.
- Byte address is {7'b0, req_addr, 1'b0}.
- Nibble stream, sent MSN first within every field:
  - command byte: 2 nibbles;
  - address: 6 nibbles;
  - reads only: DUMMY_NIBBLES nibbles;
  - data: 4 nibbles.
- Nibble count N: read = 8 + DUMMY_NIBBLES + 4 (default 14); write = 12.
- Each nibble occupies 2 clk cycles:
  - phase 0: sck=0, new sio_out value presented;
  - phase 1: sck=1, sio_out held.
  - Reads sample sio_in at the end of phase 1, i.e. the edge where sck falls.
- cs_n is low for exactly cycles T+1 .. T+2N.
- sio_oe:
  - 1 during command, address and write-data nibbles;
  - 0 during dummy and read-data nibbles;
  - 0 whenever cs_n is 1.
- States: IDLE -> CMD -> ADDR -> (read: DUMMY, skipped if DUMMY_NIBBLES=0) -> DATA -> RESP -> GAP -> IDLE.
- RESP (cycle T+2N+1):
  - cs_n=1, sck=0, rsp_valid=1;
  - rsp_rdata updated for reads, unchanged for writes.
- GAP (cycle T+2N+2): cs_n=1, req_ready=1, so a new request can be accepted at this edge. This guarantees cs_n is high for at least 2 cycles between transactions.
- Requests while req_ready=0 are ignored; the core must hold req_valid.
- sck toggles only while cs_n=0 and idles low.
- Back-to-back requests are accepted every 2N+2 cycles.
- Address wrap is not performed by the controller: 0xFFFF maps to byte address 0x01FFFE.

Test Plan:
- Reset then read addr 0x1234; SRAM model returns 0xBEEF.
  - Required: nibbles 0,3 | 0,0,2,4,6,8 | 2 dummy with sio_oe=0.
  - Required: cs_n low for 28 cycles; rsp_valid at T+29 with rsp_rdata=0xBEEF.
- Write 0xA5C3 to addr 0x0001.
  - Required: nibbles 0,2,0,0,0,0,0,2,A,5,C,3 with sio_oe=1 throughout.
  - Required: rsp_valid at T+25; rsp_rdata still 0xBEEF.
- req_valid held high for two reads.
  - Required: second accept exactly 30 cycles after the first, with cs_n high for 2 cycles in between.
- Pulse req_valid during a busy transaction.
  - Required: no accept and no pin disturbance; the transaction completes normally.
- Assert rst at the 10th cycle of a read.
  - Required: next cycle cs_n=1, sck=0, sio_oe=0, rsp_valid never pulses.
  - Required: req_ready=1 one cycle after rst is released.
- Read addr 0xFFFF.
  - Required: address nibbles 0,1,F,F,F,E.

Source files
------------

// File: rtl/idli_sqi_mem_ctrl.sv
// Quad-SPI SRAM sequencer: turns one 16-bit word request from the idli core into a
// complete SQI transaction (command, address, dummy, data) on the uio pins.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | cs_n high, waiting for a request
// S_CMD   | shifting out the 2 command nibbles
// S_ADDR  | shifting out the 6 byte-address nibbles
// S_DUMMY | read turnaround, pins released
// S_DATA  | 4 data nibbles, driven for writes and sampled for reads
// S_RESP  | cs_n high, rsp_valid pulse
// S_GAP   | cs_n high, next request may be accepted
module idli_sqi_mem_ctrl #(
    parameter logic [7:0] CMD_READ      = 8'h03,
    parameter logic [7:0] CMD_WRITE     = 8'h02,
    parameter int         DUMMY_NIBBLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        sck,
    output logic        cs_n,
    output logic [3:0]  sio_out,
    output logic        sio_oe,
    input  logic [3:0]  sio_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_RESP,
        S_GAP
    } state_t;

    localparam logic [2:0] DUMMY_LOAD = (DUMMY_NIBBLES > 0) ? 3'(DUMMY_NIBBLES - 1) : 3'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_phase;
    logic        w_phase_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_we;
    logic        w_we_nxt;
    logic [47:0] r_sh;
    logic        r_cs_n;
    logic        r_sck;
    logic        r_sio_oe;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic        w_accept;
    logic        w_shift;
    logic        w_last;
    logic        w_active_nxt;
    logic        w_oe_nxt;

    assign req_ready = !rst && ((r_state == S_IDLE) || (r_state == S_GAP));
    assign w_accept  = req_valid && req_ready;
    assign w_we_nxt  = w_accept ? req_we : r_we;
    assign w_last    = (r_state == S_DATA) && r_phase && (r_cnt == 3'd0);
    assign w_shift   = r_phase && ((r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA));

    // r_cnt counts down the nibbles left in the current field; each nibble is a
    // phase-0 (sck low) cycle followed by a phase-1 (sck high) cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_GAP: begin
                if (w_accept) begin
                    w_state_nxt = S_CMD;
                    w_phase_nxt = 1'b0;
                    w_cnt_nxt   = 3'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                w_phase_nxt = !r_phase;
                if (r_phase) begin
                    if (r_cnt != 3'd0) begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end else begin
                        case (r_state)
                            S_CMD: begin
                                w_state_nxt = S_ADDR;
                                w_cnt_nxt   = 3'd5;
                            end
                            S_ADDR: begin
                                if (r_we || (DUMMY_NIBBLES == 0)) begin
                                    w_state_nxt = S_DATA;
                                    w_cnt_nxt   = 3'd3;
                                end else begin
                                    w_state_nxt = S_DUMMY;
                                    w_cnt_nxt   = DUMMY_LOAD;
                                end
                            end
                            S_DUMMY: begin
                                w_state_nxt = S_DATA;
                                w_cnt_nxt   = 3'd3;
                            end
                            default: begin
                                w_state_nxt = S_RESP;
                                w_cnt_nxt   = 3'd0;
                            end
                        endcase
                    end
                end
            end
            S_RESP:  w_state_nxt = S_GAP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pin controls are decoded from the next state so they leave the block straight from flops.
    assign w_active_nxt = (w_state_nxt == S_CMD) || (w_state_nxt == S_ADDR) ||
                          (w_state_nxt == S_DUMMY) || (w_state_nxt == S_DATA);
    assign w_oe_nxt     = (w_state_nxt == S_CMD) || (w_state_nxt == S_ADDR) ||
                          ((w_state_nxt == S_DATA) && w_we_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // One shift register carries the whole outgoing stream; read nibbles enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_sh        <= 48'd0;
            r_cs_n      <= 1'b1;
            r_sck       <= 1'b0;
            r_sio_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'd0;
        end else begin
            r_we <= w_we_nxt;
            if (w_accept) begin
                r_sh <= {(req_we ? CMD_WRITE : CMD_READ), 7'd0, req_addr, 1'b0, req_wdata};
            end else if (w_shift) begin
                r_sh <= {r_sh[43:0], sio_in};
            end
            r_cs_n      <= !w_active_nxt;
            r_sck       <= w_active_nxt && w_phase_nxt;
            r_sio_oe    <= w_oe_nxt;
            r_rsp_valid <= w_last;
            if (w_last && !r_we) begin
                r_rsp_rdata <= {r_sh[11:0], sio_in};
            end
        end
    end

    assign cs_n      = r_cs_n;
    assign sck       = r_sck;
    assign sio_out   = r_sh[47:44];
    assign sio_oe    = r_sio_oe;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
